spi_frame_streamer: RTL and testbench
=====================================

Name: spi_frame_streamer

Overview:
Parametrised SPI slave (mode 0) that streams a fixed-format oscilloscope frame to the host MCU: header, trigger level, N_SAMPLES capture bytes read from a sample buffer, N_WORDS 32-bit measurement words, and a trailer. It also returns every byte received on MOSI. It is the generalised successor of the fixed 213-byte SPI frame controller. New capabilities are frame resync on CS_N, coherent word snapshots, buffer-addressed samples, and frame status strobes. It sits between the capture RAM / frequency counters and the MCU SPI pins.

Parameters:
N_SAMPLES, 200, number of sample bytes per frame (>=1)
N_WORDS, 2, number of 32-bit words per frame (>=1)
AW, 8, sample-buffer address width (2^AW >= N_SAMPLES)
HDR0, 8'h55, first header byte; trailer byte 2 equals HDR0
HDR1, 8'hAA, second header byte; trailer byte 1 equals HDR1

Ports:
sys_clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous, active-high reset
cs_n  in  1  SPI chip select, active low, asynchronous to sys_clk
sck  in  1  SPI clock, asynchronous, CPOL=0, at most sys_clk/8
mosi  in  1  SPI data from master
miso  out  1  SPI data to master
trigger_voltage  in  8  trigger level, frame byte 2
words_in  in  32*N_WORDS  measurement words; word 0 = bits [31:0]
smp_addr  out  AW  sample-buffer read address
smp_data  in  8  sample-buffer data, valid 1 sys_clk after smp_addr
rxd_data  out  8  last byte received on MOSI
rxd_valid  out  1  1-cycle strobe when rxd_data updates
byte_idx  out  16  index of the byte currently being shifted out
frame_start  out  1  1-cycle strobe when byte 0 is loaded
frame_done  out  1  1-cycle strobe when the last frame byte completes

Behaviour:
- Clock and reset: single sys_clk domain; rst asynchronous, active high.
- Input sync: cs_n, sck, mosi each pass through a 2-FF synchroniser. Edges are detected on the synchronised sck; all logic is sys_clk-based.
- Frame layout, L = 5 + N_SAMPLES + 4*N_WORDS (213 at defaults):
  - idx 0: HDR0; idx 1: HDR1; idx 2: trigger snapshot.
  - idx 3 .. 2+N_SAMPLES: smp_data at address idx-3.
  - Next 4*N_WORDS bytes: word 0 first, each word MSB first.
  - idx L-2: HDR1; idx L-1: HDR0.
- Snapshot: trigger_voltage and all of words_in are latched into a shadow register on the cycle frame_start fires. Frame bytes come only from the shadow, so words stay coherent.
- SPI mode 0 (CPOL=0, CPHA=0):
  - MOSI is sampled on synchronised sck rising edges.
  - miso changes on synchronised sck falling edges.
  - On the cs_n falling edge (synchronised), load byte 0 and drive its MSB on miso immediately. Pulse frame_start.
- Per byte:
  - The 8th rising edge completes the byte.
  - rxd_data <= received byte and rxd_valid pulses 1 cycle later.
  - byte_idx increments, or wraps to 0 after L-1.
  - The prefetched next byte loads into the tx shifter; its MSB appears on the next falling edge.
- Prefetch: when byte k loads, the block computes byte k+1. smp_addr is presented immediately; the byte is registered when smp_data is valid (2 cycles). This fits within the sys_clk/8 minimum SCK half-period.
- Wrap: after byte L-1 completes, pulse frame_done. If cs_n is still low, continue from byte 0: take a new snapshot and pulse frame_start in the same cycle as the byte-0 load.
- CS_N rise mid-frame:
  - byte_idx resets to 0 and the partial rx byte is discarded (no rxd_valid).
  - frame_done is not pulsed; miso drives 0.
  - The next cs_n fall starts a new frame.
- cs_n high: sck edges are ignored and miso = 0 (no tristate; the top level handles it).
- Simultaneous events: a cs_n rise in the same cycle as the 8th rising edge gives abort priority; no rxd_valid and no frame_done.
- Reset values: miso 0, rxd_data 0, rxd_valid 0, byte_idx 0, smp_addr 0, frame_start 0, frame_done 0, shadow registers 0. Reset mid-transfer aborts the frame with no strobes.
- smp_addr is held outside the sample region; only data fetched during idx 3..2+N_SAMPLES is used.

Test Plan:
- Defaults: words_in = {32'h0000_1234, 32'h05F5_E100}, trigger 8'h80, buffer[a]=a; clock 213 bytes → miso: 55 AA 80 00..C7 05 F5 E1 00 00 00 12 34 AA 55; frame_done once, frame_start once.
- Hold cs_n low for 430 bytes → two identical frames back-to-back, byte_idx wraps 212→0, and frame_start fires at byte 213.
- Change words_in at byte 204 of the default frame → bytes 203..210 still carry the values from the start-of-frame snapshot.
- Raise cs_n after 3 bits of byte 50, then restart → no rxd_valid and no frame_done for the aborted byte; the new frame starts at 55.
- Master sends MOSI bytes A5, 3C, FF → rxd_valid pulses 3 times, each 1 cycle, with rxd_data = A5, 3C, FF.
- N_SAMPLES=4, N_WORDS=1: 13-byte frame 55 AA trig s0..s3 w[31:24]..w[7:0] AA 55 is correct. Asserting rst at byte 7 forces all outputs to reset values, and the next frame starts at 55.

Source files
------------

// File: rtl/spi_frame_streamer.sv
// SPI mode-0 slave that streams a header / trigger / sample / word / trailer frame
// and returns every byte received on MOSI. All logic runs on sys_clk.
module spi_frame_streamer #(
  parameter int unsigned N_SAMPLES = 200,
  parameter int unsigned N_WORDS   = 2,
  parameter int unsigned AW        = 8,
  parameter logic [7:0]  HDR0      = 8'h55,
  parameter logic [7:0]  HDR1      = 8'hAA
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   cs_n,
  input  logic                   sck,
  input  logic                   mosi,
  output logic                   miso,
  input  logic [7:0]             trigger_voltage,
  input  logic [32*N_WORDS-1:0]  words_in,
  output logic [AW-1:0]          smp_addr,
  input  logic [7:0]             smp_data,
  output logic [7:0]             rxd_data,
  output logic                   rxd_valid,
  output logic [15:0]            byte_idx,
  output logic                   frame_start,
  output logic                   frame_done
);

  localparam int unsigned FRAME_LEN  = 5 + N_SAMPLES + 4 * N_WORDS;
  localparam logic [15:0] LAST_IDX   = 16'(FRAME_LEN - 1);
  localparam logic [15:0] TRL_IDX    = 16'(FRAME_LEN - 2);
  localparam logic [15:0] SMP_FIRST  = 16'd3;
  localparam logic [15:0] SMP_LAST   = 16'(N_SAMPLES + 2);
  localparam logic [15:0] WORD_FIRST = 16'(N_SAMPLES + 3);

  typedef enum logic [1:0] {PF_IDLE, PF_ADDR, PF_DATA} pf_state_e;

  function automatic logic [15:0] idx_inc(input logic [15:0] i);
    return (i == LAST_IDX) ? 16'd0 : i + 16'd1;
  endfunction

  // NOTE: cs_n/sck/mosi are asynchronous; two flops each before any logic sees them.
  logic [1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
  logic       cs_prev_q, sck_prev_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cs_sync_q   <= 2'b11;
      sck_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], cs_n};
      sck_sync_q  <= {sck_sync_q[0], sck};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      cs_prev_q   <= cs_sync_q[1];
      sck_prev_q  <= sck_sync_q[1];
    end
  end

  logic cs_s, mosi_s, cs_fall, sck_rise, sck_fall;
  assign cs_s     = cs_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign sck_rise = sck_sync_q[1] & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q[1] & sck_prev_q;

  pf_state_e              pf_q;
  logic [15:0]            byte_idx_q, fetch_idx_q;
  logic [7:0]             tx_shift_q, next_byte_q, rxd_data_q, trig_shadow_q;
  logic [6:0]             rx_shift_q;
  logic [2:0]             rx_cnt_q;
  logic [AW-1:0]          smp_addr_q;
  logic                   miso_q, rxd_valid_q, frame_start_q, frame_done_q;
  logic [32*N_WORDS-1:0]  words_shadow_q;

  logic [15:0] nxt_idx, launch_idx, word_off;
  logic [31:0] word_sel;
  logic [7:0]  fetch_byte;

  assign nxt_idx    = idx_inc(byte_idx_q);
  assign launch_idx = cs_fall ? 16'd1 : idx_inc(nxt_idx);
  assign word_off   = fetch_idx_q - WORD_FIRST;
  assign word_sel   = 32'(words_shadow_q >> {word_off[15:2], 5'b0});

  // Frame bytes come from constants, the shadow registers, or the sample buffer.
  always_comb begin
    fetch_byte = HDR0;
    if (fetch_idx_q == 16'd1 || fetch_idx_q == TRL_IDX)
      fetch_byte = HDR1;
    else if (fetch_idx_q == 16'd2)
      fetch_byte = trig_shadow_q;
    else if (fetch_idx_q >= SMP_FIRST && fetch_idx_q <= SMP_LAST)
      fetch_byte = smp_data;
    else if (fetch_idx_q >= WORD_FIRST && fetch_idx_q < TRL_IDX)
      fetch_byte = 8'(word_sel >> {~word_off[1:0], 3'b0});
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      pf_q           <= PF_IDLE;
      byte_idx_q     <= '0;
      fetch_idx_q    <= '0;
      tx_shift_q     <= '0;
      next_byte_q    <= '0;
      rxd_data_q     <= '0;
      trig_shadow_q  <= '0;
      rx_shift_q     <= '0;
      rx_cnt_q       <= '0;
      smp_addr_q     <= '0;
      miso_q         <= 1'b0;
      rxd_valid_q    <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_done_q   <= 1'b0;
      words_shadow_q <= '0;
    end else begin
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      rxd_valid_q   <= 1'b0;

      // smp_data is valid one cycle after smp_addr registers, so capture two cycles after launch.
      case (pf_q)
        PF_ADDR: pf_q <= PF_DATA;
        PF_DATA: begin
          next_byte_q <= fetch_byte;
          pf_q        <= PF_IDLE;
        end
        default: pf_q <= PF_IDLE;
      endcase

      if (cs_s) begin
        byte_idx_q <= '0;
        rx_cnt_q   <= '0;
        miso_q     <= 1'b0;
        pf_q       <= PF_IDLE;
      end else if (cs_fall) begin
        byte_idx_q     <= '0;
        rx_cnt_q       <= '0;
        tx_shift_q     <= {HDR0[6:0], 1'b0};
        miso_q         <= HDR0[7];
        frame_start_q  <= 1'b1;
        trig_shadow_q  <= trigger_voltage;
        words_shadow_q <= words_in;
        fetch_idx_q    <= launch_idx;
        pf_q           <= PF_ADDR;
      end else begin
        if (sck_rise) begin
          rx_shift_q <= {rx_shift_q[5:0], mosi_s};
          rx_cnt_q   <= rx_cnt_q + 3'd1;
          if (rx_cnt_q == 3'd7) begin
            rxd_data_q  <= {rx_shift_q, mosi_s};
            rxd_valid_q <= 1'b1;
            byte_idx_q  <= nxt_idx;
            tx_shift_q  <= next_byte_q;
            fetch_idx_q <= launch_idx;
            pf_q        <= PF_ADDR;
            if (launch_idx >= SMP_FIRST && launch_idx <= SMP_LAST)
              smp_addr_q <= AW'(launch_idx - SMP_FIRST);
            if (byte_idx_q == LAST_IDX) begin
              frame_done_q   <= 1'b1;
              frame_start_q  <= 1'b1;
              trig_shadow_q  <= trigger_voltage;
              words_shadow_q <= words_in;
            end
          end
        end
        if (sck_fall) begin
          miso_q     <= tx_shift_q[7];
          tx_shift_q <= {tx_shift_q[6:0], 1'b0};
        end
      end
    end
  end

  assign miso        = miso_q;
  assign smp_addr    = smp_addr_q;
  assign rxd_data    = rxd_data_q;
  assign rxd_valid   = rxd_valid_q;
  assign byte_idx    = byte_idx_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_spi_frame_streamer.sv
// Directed bench for spi_frame_streamer: default 213-byte frame and a 13-byte
// (N_SAMPLES=4, N_WORDS=1) instance sharing the SPI clock and data lines.
module tb_spi_frame_streamer;

  localparam int HALF = 4;
  localparam int L    = 213;

  typedef struct {
    int         idx;
    logic [7:0] exp;
  } vec_t;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        rst, rst_s, cs_n, cs_n_s, sck, mosi;
  logic [7:0]  trig, trig_s;
  logic [63:0] words;
  logic [31:0] words_s;

  logic        miso, rxd_valid, frame_start, frame_done;
  logic [7:0]  smp_addr, smp_data, rxd_data;
  logic [15:0] byte_idx;

  logic        miso_s, rxd_valid_s, frame_start_s, frame_done_s;
  logic [1:0]  smp_addr_s;
  logic [7:0]  smp_data_s, rxd_data_s;
  logic [15:0] byte_idx_s;

  spi_frame_streamer dut (
    .sys_clk(sys_clk), .rst(rst), .cs_n(cs_n), .sck(sck), .mosi(mosi), .miso(miso),
    .trigger_voltage(trig), .words_in(words), .smp_addr(smp_addr), .smp_data(smp_data),
    .rxd_data(rxd_data), .rxd_valid(rxd_valid), .byte_idx(byte_idx),
    .frame_start(frame_start), .frame_done(frame_done)
  );

  spi_frame_streamer #(.N_SAMPLES(4), .N_WORDS(1), .AW(2)) dut_s (
    .sys_clk(sys_clk), .rst(rst_s), .cs_n(cs_n_s), .sck(sck), .mosi(mosi), .miso(miso_s),
    .trigger_voltage(trig_s), .words_in(words_s), .smp_addr(smp_addr_s), .smp_data(smp_data_s),
    .rxd_data(rxd_data_s), .rxd_valid(rxd_valid_s), .byte_idx(byte_idx_s),
    .frame_start(frame_start_s), .frame_done(frame_done_s)
  );

  // Sample buffers: default holds buffer[a] = a, small instance holds 8'hC0 + a.
  always @(posedge sys_clk) begin
    smp_data   <= smp_addr;
    smp_data_s <= 8'hC0 + {6'd0, smp_addr_s};
  end

  int n_checks = 0;
  int n_fail   = 0;

  int fs_solo = 0, fs_wrap = 0, fd_cnt = 0, rxv_cnt = 0, rxv_wide = 0;
  int fs_s = 0, fd_s = 0;
  logic rxv_prev = 1'b0;
  logic [7:0] rx_log[$];

  always @(negedge sys_clk) begin
    if (frame_start && !frame_done) fs_solo++;
    if (frame_start && frame_done)  fs_wrap++;
    if (frame_done) fd_cnt++;
    if (rxd_valid) begin
      rxv_cnt++;
      rx_log.push_back(rxd_data);
    end
    if (rxd_valid && rxv_prev) rxv_wide++;
    rxv_prev = rxd_valid;
    if (frame_start_s) fs_s++;
    if (frame_done_s)  fd_s++;
  end

  logic [7:0] got[430];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic spi_bits(input bit sel, input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      tick(HALF);
      rx  = {rx[6:0], sel ? miso_s : miso};
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic xfer(input bit sel, input int first, input int n);
    logic [7:0] r;
    for (int i = first; i < first + n; i++) begin
      spi_bits(sel, 8'(i), 8, r);
      got[i] = r;
    end
  endtask

  function automatic logic [7:0] model_byte(input int idx, input logic [7:0] tv,
                                            input logic [63:0] w);
    int off;
    if (idx == 0 || idx == 212) return 8'h55;
    if (idx == 1 || idx == 211) return 8'hAA;
    if (idx == 2) return tv;
    if (idx <= 202) return 8'(idx - 3);
    off = idx - 203;
    return w[(off / 4) * 32 + (3 - off % 4) * 8 +: 8];
  endfunction

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[18];
    vec_t tab_s[13];
    logic [7:0]  r;
    int base_fs, base_fw, base_fd, base_rxv, base_wide, base_fss, base_fds, errs;

    tab = '{'{0, 8'h55}, '{1, 8'hAA}, '{2, 8'h80}, '{3, 8'h00}, '{4, 8'h01},
            '{102, 8'h63}, '{202, 8'hC7}, '{203, 8'h05}, '{204, 8'hF5}, '{205, 8'hE1},
            '{206, 8'h00}, '{207, 8'h00}, '{208, 8'h00}, '{209, 8'h12}, '{210, 8'h34},
            '{211, 8'hAA}, '{212, 8'h55}, '{100, 8'h61}};
    tab_s = '{'{0, 8'h55}, '{1, 8'hAA}, '{2, 8'h3E}, '{3, 8'hC0}, '{4, 8'hC1},
              '{5, 8'hC2}, '{6, 8'hC3}, '{7, 8'hDE}, '{8, 8'hAD}, '{9, 8'hBE},
              '{10, 8'hEF}, '{11, 8'hAA}, '{12, 8'h55}};

    rst = 1'b1; rst_s = 1'b1; cs_n = 1'b1; cs_n_s = 1'b1; sck = 1'b0; mosi = 1'b0;
    trig = 8'h80; words = {32'h0000_1234, 32'h05F5_E100};
    trig_s = 8'h3E; words_s = 32'hDEAD_BEEF;
    tick(4);
    check("reset miso", {31'd0, miso}, 0);
    check("reset rxd_data", {24'd0, rxd_data}, 0);
    check("reset rxd_valid", {31'd0, rxd_valid}, 0);
    check("reset byte_idx", {16'd0, byte_idx}, 0);
    check("reset smp_addr", {24'd0, smp_addr}, 0);
    check("reset frame_start", {31'd0, frame_start}, 0);
    check("reset frame_done", {31'd0, frame_done}, 0);
    rst = 1'b0; rst_s = 1'b0;
    tick(4);

    // Default frame: 213 bytes, MOSI carries the byte index.
    base_fs = fs_solo; base_fw = fs_wrap; base_fd = fd_cnt;
    rx_log.delete();
    cs_n = 1'b0; tick(6);
    xfer(1'b0, 0, L);
    for (int i = 0; i < 18; i++)
      check($sformatf("frame byte %0d", tab[i].idx), {24'd0, got[tab[i].idx]}, {24'd0, tab[i].exp});
    errs = 0;
    for (int i = 0; i < L; i++)
      if (got[i] !== model_byte(i, 8'h80, words)) errs++;
    check("frame bytes differing from model", errs, 0);
    check("frame_start before wrap", fs_solo - base_fs, 1);
    check("frame_done count", fd_cnt - base_fd, 1);
    check("frame_start at wrap", fs_wrap - base_fw, 1);
    check("byte_idx wrapped", {16'd0, byte_idx}, 0);
    check("rx byte count", rx_log.size(), L);
    check("rx byte 100", {24'd0, rx_log[100]}, 32'h64);
    check("rx byte 212", {24'd0, rx_log[212]}, 32'hD4);
    tick(HALF); cs_n = 1'b1; tick(8);
    check("idle miso after frame", {31'd0, miso}, 0);

    // Two back-to-back frames plus four bytes with cs_n held low.
    base_fw = fs_wrap; base_fd = fd_cnt;
    cs_n = 1'b0; tick(6);
    xfer(1'b0, 0, 212);
    check("byte_idx at last byte", {16'd0, byte_idx}, 212);
    xfer(1'b0, 212, 1);
    check("byte_idx wrap 212->0", {16'd0, byte_idx}, 0);
    check("frame_start at byte 213", fs_wrap - base_fw, 1);
    xfer(1'b0, 213, 430 - 213);
    errs = 0;
    for (int i = 0; i < L; i++)
      if (got[i + L] !== model_byte(i, 8'h80, words)) errs++;
    check("second frame bytes differing", errs, 0);
    check("tail bytes 426..429", {got[426], got[427], got[428], got[429]}, 32'h55AA_8000);
    check("frame_done count two frames", fd_cnt - base_fd, 2);
    tick(HALF); cs_n = 1'b1; tick(8);

    // Words and trigger change at byte 204: the frame keeps its snapshot.
    cs_n = 1'b0; tick(6);
    for (int i = 0; i < L; i++) begin
      if (i == 204) begin
        words = 64'hFFFF_FFFF_FFFF_FFFF;
        trig  = 8'h11;
      end
      spi_bits(1'b0, 8'(i), 8, r);
      got[i] = r;
    end
    errs = 0;
    for (int i = 203; i <= 210; i++)
      if (got[i] !== model_byte(i, 8'h80, {32'h0000_1234, 32'h05F5_E100})) errs++;
    check("snapshot bytes 203..210 differing", errs, 0);
    check("snapshot byte 209", {24'd0, got[209]}, 32'h12);
    tick(HALF); cs_n = 1'b1; tick(8);
    trig = 8'h80; words = {32'h0000_1234, 32'h05F5_E100};

    // cs_n rises after 3 bits of byte 50, then a new frame starts.
    base_fs = fs_solo; base_fd = fd_cnt; base_rxv = rxv_cnt;
    cs_n = 1'b0; tick(6);
    xfer(1'b0, 0, 50);
    spi_bits(1'b0, 8'hFF, 3, r);
    tick(2); cs_n = 1'b1; tick(8);
    check("abort rxd_valid count", rxv_cnt - base_rxv, 50);
    check("abort frame_done", fd_cnt - base_fd, 0);
    check("abort byte_idx", {16'd0, byte_idx}, 0);
    check("abort miso", {31'd0, miso}, 0);
    spi_bits(1'b0, 8'hFF, 8, r);
    tick(6);
    check("sck ignored while deselected", rxv_cnt - base_rxv, 50);
    cs_n = 1'b0; tick(6);
    spi_bits(1'b0, 8'h00, 8, r);
    check("restart byte 0", {24'd0, r}, 32'h55);
    spi_bits(1'b0, 8'h00, 8, r);
    check("restart byte 1", {24'd0, r}, 32'hAA);
    check("restart frame_start count", fs_solo - base_fs, 2);
    tick(HALF); cs_n = 1'b1; tick(8);

    // MOSI receive path, then cs_n rise coinciding with the 8th rising edge.
    base_wide = rxv_wide; base_fd = fd_cnt;
    rx_log.delete();
    cs_n = 1'b0; tick(6);
    spi_bits(1'b0, 8'hA5, 8, r);
    spi_bits(1'b0, 8'h3C, 8, r);
    spi_bits(1'b0, 8'hFF, 8, r);
    tick(4);
    check("rx strobe count", rx_log.size(), 3);
    check("rx byte A5", {24'd0, rx_log[0]}, 32'hA5);
    check("rx byte 3C", {24'd0, rx_log[1]}, 32'h3C);
    check("rx byte FF", {24'd0, rx_log[2]}, 32'hFF);
    check("rxd_valid wider than 1 cycle", rxv_wide - base_wide, 0);
    spi_bits(1'b0, 8'h77, 7, r);
    mosi = 1'b1;
    tick(HALF);
    cs_n = 1'b1; sck = 1'b1;
    tick(HALF);
    sck = 1'b0;
    tick(8);
    check("simultaneous abort rxd_valid", rx_log.size(), 3);
    check("simultaneous abort frame_done", fd_cnt - base_fd, 0);
    check("simultaneous abort byte_idx", {16'd0, byte_idx}, 0);

    // Small instance: full 13-byte frame.
    base_fds = fd_s;
    cs_n_s = 1'b0; tick(6);
    xfer(1'b1, 0, 13);
    for (int i = 0; i < 13; i++)
      check($sformatf("small byte %0d", tab_s[i].idx), {24'd0, got[tab_s[i].idx]}, {24'd0, tab_s[i].exp});
    check("small frame_done count", fd_s - base_fds, 1);
    tick(HALF); cs_n_s = 1'b1; tick(8);

    // Small instance: reset asserted partway into byte 7.
    cs_n_s = 1'b0; tick(6);
    for (int i = 0; i < 7; i++) spi_bits(1'b1, 8'h9C, 8, r);
    check("small byte_idx before reset", {16'd0, byte_idx_s}, 7);
    spi_bits(1'b1, 8'hFF, 3, r);
    rst_s = 1'b1;
    tick(2);
    check("small reset miso", {31'd0, miso_s}, 0);
    check("small reset rxd_data", {24'd0, rxd_data_s}, 0);
    check("small reset rxd_valid", {31'd0, rxd_valid_s}, 0);
    check("small reset byte_idx", {16'd0, byte_idx_s}, 0);
    check("small reset smp_addr", {30'd0, smp_addr_s}, 0);
    check("small reset strobes", {30'd0, frame_start_s, frame_done_s}, 0);
    base_fss = fs_s; base_fds = fd_s;
    cs_n_s = 1'b1; tick(4);
    rst_s = 1'b0; tick(8);
    check("small no strobes across reset", (fs_s - base_fss) + (fd_s - base_fds), 0);
    cs_n_s = 1'b0; tick(6);
    spi_bits(1'b1, 8'h00, 8, r);
    check("small post-reset byte 0", {24'd0, r}, 32'h55);
    spi_bits(1'b1, 8'h00, 8, r);
    check("small post-reset byte 1", {24'd0, r}, 32'hAA);
    tick(HALF); cs_n_s = 1'b1; tick(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
